// File: rtl/blob_anchor_extractor.sv
// Accumulates the bounding box of colour-mask hits over a frame and reports the
// bottom-centre ground-contact point of the blob once per completed frame.
module blob_anchor_extractor #(
    parameter int unsigned IMAGE_W    = 640,
    parameter int unsigned IMAGE_H    = 480,
    parameter int unsigned MIN_PIXELS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic        in_hit,
    output logic [10:0] x_coord,
    output logic [10:0] y_coord,
    output logic        coord_valid,
    output logic        detected,
    output logic [18:0] pixel_count,
    output logic        frame_err
);

    localparam int unsigned POS_W = 11;
    localparam int unsigned CNT_W = 19;
    localparam int unsigned SUM_W = 12;

    localparam logic [POS_W-1:0] X_LAST    = POS_W'(IMAGE_W - 1);
    localparam logic [POS_W-1:0] Y_LAST    = POS_W'(IMAGE_H - 1);
    localparam logic [POS_W-1:0] XMIN_INIT = '1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] MIN_CNT   = CNT_W'(MIN_PIXELS);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ACCUM = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [POS_W-1:0] pos_x, pos_x_nxt, pos_y, pos_y_nxt;
    logic             pos_sat, pos_sat_nxt;
    logic [POS_W-1:0] xmin, xmin_nxt, xmax, xmax_nxt, ymax, ymax_nxt;
    logic [CNT_W-1:0] count, count_nxt;

    logic [POS_W-1:0] x_coord_nxt, y_coord_nxt;
    logic             coord_valid_nxt, detected_nxt, frame_err_nxt;
    logic [CNT_W-1:0] pixel_count_nxt;

    // Position and accumulator base for this beat; a sop beat restarts at (0,0).
    logic [POS_W-1:0] cur_x, cur_y, base_xmin, base_xmax, base_ymax;
    logic             cur_sat, hit_ok, beat_live;
    logic [CNT_W-1:0] base_count;
    logic [POS_W-1:0] m_xmin, m_xmax, m_ymax;
    logic [CNT_W-1:0] m_count;
    logic [SUM_W-1:0] x_sum;

    assign cur_x      = in_sop ? '0 : pos_x;
    assign cur_y      = in_sop ? '0 : pos_y;
    assign cur_sat    = in_sop ? 1'b0 : pos_sat;
    assign base_xmin  = in_sop ? XMIN_INIT : xmin;
    assign base_xmax  = in_sop ? '0 : xmax;
    assign base_ymax  = in_sop ? '0 : ymax;
    assign base_count = in_sop ? '0 : count;
    assign beat_live  = in_valid && (in_sop || (state == S_ACCUM));

    // Hits past the last real pixel land on a saturated position and are dropped.
    assign hit_ok  = in_hit && !cur_sat;
    assign m_xmin  = (hit_ok && (cur_x < base_xmin)) ? cur_x : base_xmin;
    assign m_xmax  = (hit_ok && (cur_x > base_xmax)) ? cur_x : base_xmax;
    assign m_ymax  = (hit_ok && (cur_y > base_ymax)) ? cur_y : base_ymax;
    assign m_count = (hit_ok && (base_count != CNT_MAX)) ? base_count + CNT_W'(1) : base_count;
    assign x_sum   = SUM_W'(m_xmin) + SUM_W'(m_xmax);

    always_comb begin
        state_nxt       = state;
        pos_x_nxt       = pos_x;
        pos_y_nxt       = pos_y;
        pos_sat_nxt     = pos_sat;
        xmin_nxt        = xmin;
        xmax_nxt        = xmax;
        ymax_nxt        = ymax;
        count_nxt       = count;
        x_coord_nxt     = x_coord;
        y_coord_nxt     = y_coord;
        coord_valid_nxt = 1'b0;
        detected_nxt    = detected;
        pixel_count_nxt = pixel_count;
        frame_err_nxt   = frame_err;

        if (beat_live) begin
            if (in_eop) begin
                coord_valid_nxt = 1'b1;
                pixel_count_nxt = m_count;
                frame_err_nxt   = !((cur_x == X_LAST) && (cur_y == Y_LAST));
                if (m_count >= MIN_CNT) begin
                    detected_nxt = 1'b1;
                    x_coord_nxt  = POS_W'(x_sum >> 1);
                    y_coord_nxt  = m_ymax;
                end else begin
                    detected_nxt = 1'b0;
                end
                xmin_nxt    = XMIN_INIT;
                xmax_nxt    = '0;
                ymax_nxt    = '0;
                count_nxt   = '0;
                pos_x_nxt   = '0;
                pos_y_nxt   = '0;
                pos_sat_nxt = 1'b0;
                state_nxt   = S_IDLE;
            end else begin
                xmin_nxt  = m_xmin;
                xmax_nxt  = m_xmax;
                ymax_nxt  = m_ymax;
                count_nxt = m_count;
                state_nxt = S_ACCUM;
                if (cur_sat) begin
                    pos_x_nxt   = X_LAST;
                    pos_y_nxt   = Y_LAST;
                    pos_sat_nxt = 1'b1;
                end else if (cur_x == X_LAST) begin
                    if (cur_y == Y_LAST) begin
                        pos_x_nxt   = X_LAST;
                        pos_y_nxt   = Y_LAST;
                        pos_sat_nxt = 1'b1;
                    end else begin
                        pos_x_nxt   = '0;
                        pos_y_nxt   = cur_y + POS_W'(1);
                        pos_sat_nxt = 1'b0;
                    end
                end else begin
                    pos_x_nxt   = cur_x + POS_W'(1);
                    pos_y_nxt   = cur_y;
                    pos_sat_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pos_x       <= '0;
            pos_y       <= '0;
            pos_sat     <= 1'b0;
            xmin        <= XMIN_INIT;
            xmax        <= '0;
            ymax        <= '0;
            count       <= '0;
            x_coord     <= '0;
            y_coord     <= '0;
            coord_valid <= 1'b0;
            detected    <= 1'b0;
            pixel_count <= '0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            pos_x       <= pos_x_nxt;
            pos_y       <= pos_y_nxt;
            pos_sat     <= pos_sat_nxt;
            xmin        <= xmin_nxt;
            xmax        <= xmax_nxt;
            ymax        <= ymax_nxt;
            count       <= count_nxt;
            x_coord     <= x_coord_nxt;
            y_coord     <= y_coord_nxt;
            coord_valid <= coord_valid_nxt;
            detected    <= detected_nxt;
            pixel_count <= pixel_count_nxt;
            frame_err   <= frame_err_nxt;
        end
    end

endmodule

// File: tb/tb_blob_anchor_extractor.sv
// Scoreboard bench: directed frames push hand-computed results, a negedge
// monitor checks every coord_valid pulse and that outputs hold in between.
module tb_blob_anchor_extractor;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [18:0] cnt;
        logic        det;
        logic        err;
        logic        chk_err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_valid = 0, a_sop = 0, a_eop = 0, a_hit = 0;
    logic b_valid = 0, b_sop = 0, b_eop = 0, b_hit = 0;
    logic [10:0] a_x, a_y, b_x, b_y;
    logic [18:0] a_cnt, b_cnt;
    logic a_cv, a_det, a_err, b_cv, b_det, b_err;

    int compared = 0;
    int failed = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t held[2];

    always #5 clk = ~clk;

    blob_anchor_extractor #(.IMAGE_W(8), .IMAGE_H(4), .MIN_PIXELS(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_sop(a_sop), .in_eop(a_eop),
        .in_hit(a_hit), .x_coord(a_x), .y_coord(a_y), .coord_valid(a_cv),
        .detected(a_det), .pixel_count(a_cnt), .frame_err(a_err)
    );

    blob_anchor_extractor #(.IMAGE_W(640), .IMAGE_H(8), .MIN_PIXELS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_sop(b_sop), .in_eop(b_eop),
        .in_hit(b_hit), .x_coord(b_x), .y_coord(b_y), .coord_valid(b_cv),
        .detected(b_det), .pixel_count(b_cnt), .frame_err(b_err)
    );

    function automatic bit differs(input exp_t e, input logic [10:0] x, input logic [10:0] y,
                                   input logic [18:0] cnt, input logic det, input logic err);
        return (x !== e.x) || (y !== e.y) || (cnt !== e.cnt) || (det !== e.det) ||
               (e.chk_err && (err !== e.err));
    endfunction

    task automatic mon(input int sel, input logic cv, input logic [10:0] x, input logic [10:0] y,
                       input logic [18:0] cnt, input logic det, input logic err);
        exp_t e;
        bit have;
        have = 0;
        compared++;
        if (cv) begin
            if (sel == 0 && q_a.size() > 0) begin e = q_a.pop_front(); have = 1; end
            if (sel == 1 && q_b.size() > 0) begin e = q_b.pop_front(); have = 1; end
            if (!have) begin
                failed++;
                $display("FAIL dut%0d unexpected_pulse got x=%0d y=%0d cnt=%0d det=%0d err=%0d",
                         sel, x, y, cnt, det, err);
            end else begin
                if (differs(e, x, y, cnt, det, err)) begin
                    failed++;
                    $display("FAIL dut%0d result got x=%0d y=%0d cnt=%0d det=%0d err=%0d want x=%0d y=%0d cnt=%0d det=%0d err=%0d",
                             sel, x, y, cnt, det, err, e.x, e.y, e.cnt, e.det, e.err);
                end
                held[sel] = e;
            end
        end else if (differs(held[sel], x, y, cnt, det, err)) begin
            failed++;
            $display("FAIL dut%0d hold got x=%0d y=%0d cnt=%0d det=%0d err=%0d want x=%0d y=%0d cnt=%0d det=%0d err=%0d",
                     sel, x, y, cnt, det, err, held[sel].x, held[sel].y, held[sel].cnt,
                     held[sel].det, held[sel].err);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held[0] = '{x: 0, y: 0, cnt: 0, det: 0, err: 0, chk_err: 1};
            held[1] = '{x: 0, y: 0, cnt: 0, det: 0, err: 0, chk_err: 1};
        end else begin
            mon(0, a_cv, a_x, a_y, a_cnt, a_det, a_err);
            mon(1, b_cv, b_x, b_y, b_cnt, b_det, b_err);
        end
    end

    task automatic beat(input int sel, input logic v, input logic s, input logic e, input logic h);
        a_valid = 0; a_sop = 0; a_eop = 0; a_hit = 0;
        b_valid = 0; b_sop = 0; b_eop = 0; b_hit = 0;
        if (sel == 0) begin a_valid = v; a_sop = s; a_eop = e; a_hit = h; end
        else          begin b_valid = v; b_sop = s; b_eop = e; b_hit = h; end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input int sel, input int x, input int y, input int cnt,
                                input bit det, input bit err, input bit chk);
        exp_t e;
        e = '{x: 11'(x), y: 11'(y), cnt: 19'(cnt), det: det, err: err, chk_err: chk};
        if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    endtask

    // Drives n valid beats; garbage idle cycles (valid low) are inserted when gaps is set.
    task automatic run(input int sel, input int n, input bit do_sop, input bit do_eop,
                       input int hits[$], input bit gaps);
        bit h;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 3; g++) begin
                    if ($urandom_range(99) < 30)
                        beat(sel, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
                end
            end
            h = 0;
            foreach (hits[k]) if (hits[k] == i) h = 1;
            beat(sel, 1'b1, do_sop && (i == 0), do_eop && (i == n - 1), h);
        end
    endtask

    initial begin
        int wait_cnt;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) beat(0, 0, 0, 0, 0);

        // Back-to-back frames: three hits, then a single hit below threshold.
        expect_frame(0, 3, 3, 3, 1, 0, 1);
        run(0, 32, 1, 1, '{10, 13, 27}, 0);
        expect_frame(0, 3, 3, 1, 0, 0, 1);
        run(0, 32, 1, 1, '{7}, 0);
        repeat (2) beat(0, 0, 0, 0, 0);

        // eop while idle is ignored.
        beat(0, 1, 0, 1, 1);
        repeat (2) beat(0, 0, 0, 0, 0);

        // Wide image, hits at both corners, gapped input, hit on the eop beat.
        expect_frame(1, 319, 7, 2, 1, 0, 1);
        run(1, 640 * 8, 1, 1, '{0, 640 * 8 - 1}, 1);
        repeat (2) beat(1, 0, 0, 0, 0);

        // Partial frame aborted by a new sop, then a full frame.
        run(0, 20, 1, 0, '{0, 5, 19}, 0);
        expect_frame(0, 6, 3, 2, 1, 0, 1);
        run(0, 32, 1, 1, '{22, 30}, 0);
        repeat (2) beat(0, 0, 0, 0, 0);

        // Short frame: eop at (3,2).
        expect_frame(0, 2, 2, 2, 1, 1, 1);
        run(0, 20, 1, 1, '{1, 19}, 0);
        // Overrun frame: hits after (7,3) land on the saturated position.
        expect_frame(0, 3, 3, 2, 1, 0, 0);
        run(0, 41, 1, 1, '{0, 31, 32, 33, 36, 39, 40}, 0);
        repeat (2) beat(0, 0, 0, 0, 0);

        // Reset mid-frame, then hits with no sop must be ignored.
        run(0, 10, 1, 0, '{2, 3, 9}, 0);
        rst_n = 0;
        repeat (2) beat(0, 0, 0, 0, 0);
        rst_n = 1;
        run(0, 10, 0, 0, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9}, 0);
        beat(0, 1, 0, 1, 1);
        repeat (2) beat(0, 0, 0, 0, 0);
        expect_frame(0, 3, 1, 2, 1, 0, 1);
        run(0, 32, 1, 1, '{9, 14}, 0);
        // sop and eop on the same beat with a hit.
        expect_frame(0, 3, 1, 1, 0, 1, 1);
        run(0, 1, 1, 1, '{0}, 0);

        wait_cnt = 0;
        while ((q_a.size() > 0 || q_b.size() > 0) && wait_cnt < 20) begin
            beat(0, 0, 0, 0, 0);
            wait_cnt++;
        end
        repeat (3) beat(0, 0, 0, 0, 0);
        compared++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            failed++;
            $display("FAIL missing_pulse got pending a=%0d b=%0d want 0", q_a.size(), q_b.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
